// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_reader
// Description : Walks the register file through one read port and streams
//               {index, data} beats on a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump_reader #(
    parameter int NREGS   = 32,
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int SKIP_X0 = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    output logic [AW-1:0] o_rf_addr,
    input  logic [DW-1:0] i_rf_rdata,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out_data,
    output logic [AW-1:0] o_out_idx,
    output logic          o_out_last,
    output logic          o_busy,
    output logic          o_done
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_SEND  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [AW-1:0] c_LAST_IDX  = AW'(NREGS - 1);
    localparam logic [AW-1:0] c_FIRST_IDX = (SKIP_X0 != 0) ? AW'(1) : AW'(0);

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [AW-1:0] r_idx;
    logic [DW-1:0] r_out_data;
    logic [AW-1:0] r_out_idx;
    logic          r_out_last;
    logic          w_handshake;

    assign w_handshake = (r_state == c_SEND) && i_out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (i_start && !i_abort) begin
                    w_next = c_FETCH;
                end
            end
            c_FETCH: begin
                w_next = i_abort ? c_IDLE : c_SEND;
            end
            c_SEND: begin
                if (i_abort) begin
                    w_next = c_IDLE;
                end else if (w_handshake) begin
                    w_next = r_out_last ? c_DONE : c_FETCH;
                end
            end
            c_DONE: begin
                w_next = c_IDLE;
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    // Index only advances on a non-final handshake, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_out_data <= '0;
            r_out_idx  <= '0;
            r_out_last <= 1'b0;
        end else begin
            if (r_state == c_IDLE && w_next == c_FETCH) begin
                r_idx <= c_FIRST_IDX;
            end
            if (r_state == c_FETCH && !i_abort) begin
                r_out_data <= i_rf_rdata;
                r_out_idx  <= r_idx;
                r_out_last <= (r_idx == c_LAST_IDX);
            end
            if (r_state == c_SEND && w_next == c_FETCH) begin
                r_idx <= r_idx + AW'(1);
            end
        end
    end

    always_comb begin
        o_rf_addr   = (r_state == c_FETCH) ? r_idx : '0;
        o_out_valid = (r_state == c_SEND);
        o_busy      = (r_state != c_IDLE);
        o_done      = (r_state == c_DONE);
        o_out_data  = r_out_data;
        o_out_idx   = r_out_idx;
        o_out_last  = r_out_last;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_dump_reader
// Description : Self-checking bench for regfile_dump_reader (x0 included and
//               x0 skipped instances sharing one register file model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_reader;

    typedef struct {
        int sel;      // 0: SKIP_X0=0 instance, 1: SKIP_X0=1 instance
        int stall;    // 0: ready held high, N: ready high with probability 1/(N+1)
        int first;
        int beats;
        int cycles;   // start edge to last-beat edge, -1 when ready is random
        int restart;  // index at which start is re-pulsed, -1 for none
        bit rnd;      // randomise register contents first
    } vec_t;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, ready;
    int          sel;
    logic [31:0] rf [32];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [4:0]  a_addr, b_addr, a_idx, b_idx;
    logic [31:0] a_rdata, b_rdata, a_data, b_data;
    logic        a_valid, b_valid, a_last, b_last, a_busy, b_busy, a_done, b_done;
    logic        a_start, b_start, a_abort, b_abort, a_ready, b_ready;

    logic [4:0]  v_addr, v_idx;
    logic [31:0] v_data;
    logic        v_valid, v_last, v_busy, v_done;

    always #5 clk = ~clk;

    assign a_rdata = rf[a_addr];
    assign b_rdata = rf[b_addr];
    assign a_start = start && (sel == 0);
    assign b_start = start && (sel == 1);
    assign a_abort = abort && (sel == 0);
    assign b_abort = abort && (sel == 1);
    assign a_ready = ready && (sel == 0);
    assign b_ready = ready && (sel == 1);

    assign v_addr  = (sel == 1) ? b_addr  : a_addr;
    assign v_idx   = (sel == 1) ? b_idx   : a_idx;
    assign v_data  = (sel == 1) ? b_data  : a_data;
    assign v_valid = (sel == 1) ? b_valid : a_valid;
    assign v_last  = (sel == 1) ? b_last  : a_last;
    assign v_busy  = (sel == 1) ? b_busy  : a_busy;
    assign v_done  = (sel == 1) ? b_done  : a_done;

    regfile_dump_reader #(.NREGS(32), .AW(5), .DW(32), .SKIP_X0(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_abort(a_abort),
        .o_rf_addr(a_addr), .i_rf_rdata(a_rdata), .o_out_valid(a_valid),
        .i_out_ready(a_ready), .o_out_data(a_data), .o_out_idx(a_idx),
        .o_out_last(a_last), .o_busy(a_busy), .o_done(a_done)
    );

    regfile_dump_reader #(.NREGS(32), .AW(5), .DW(32), .SKIP_X0(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_abort(b_abort),
        .o_rf_addr(b_addr), .i_rf_rdata(b_rdata), .o_out_valid(b_valid),
        .i_out_ready(b_ready), .o_out_data(b_data), .o_out_idx(b_idx),
        .o_out_last(b_last), .o_busy(b_busy), .o_done(b_done)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_addr"},  64'(v_addr),  64'd0);
        chk({nm, "_valid"}, 64'(v_valid), 64'd0);
        chk({nm, "_data"},  64'(v_data),  64'd0);
        chk({nm, "_idx"},   64'(v_idx),   64'd0);
        chk({nm, "_last"},  64'(v_last),  64'd0);
        chk({nm, "_busy"},  64'(v_busy),  64'd0);
        chk({nm, "_done"},  64'(v_done),  64'd0);
    endtask

    task automatic run_dump(input vec_t v);
        beat_t       q[$];
        beat_t       b;
        int          edges = 0, nbeats = 0, last_edge = -1, done_edge = -1;
        logic        hv = 1'b0;
        logic [31:0] hd = '0;
        logic [4:0]  hi = '0;
        bit          fin = 1'b0;
        for (int i = v.first; i < 32; i++) begin
            b.idx = 5'(i); b.data = rf[i]; b.last = (i == 31);
            q.push_back(b);
        end
        @(negedge clk);
        sel = v.sel; ready = 1'b1; start = 1'b1;
        for (int t = 0; t < 3000 && !fin; t++) begin
            @(negedge clk);
            start = 1'b0;
            edges++;
            ready = (v.stall == 0) ? 1'b1 : ($urandom_range(0, v.stall) == 0);
            if (v.restart >= 0 && v_valid && int'(v_idx) == v.restart) start = 1'b1;
            if (v_valid && hv) begin
                chk("hold_data", 64'(v_data), 64'(hd));
                chk("hold_idx",  64'(v_idx),  64'(hi));
            end
            hv = v_valid && !ready; hd = v_data; hi = v_idx;
            chk("valid_done_excl", 64'(v_valid && v_done), 64'd0);
            if (v_valid && ready) begin
                nbeats++;
                if (q.size() == 0) begin
                    chk("extra_beat", 64'(nbeats), 64'(v.beats));
                end else begin
                    b = q.pop_front();
                    chk("beat_idx",  64'(v_idx),  64'(b.idx));
                    chk("beat_data", 64'(v_data), 64'(b.data));
                    chk("beat_last", 64'(v_last), 64'(b.last));
                end
                if (v_last) last_edge = edges;
            end
            if (v_done) begin
                done_edge = edges;
                fin = 1'b1;
            end
        end
        if (!fin) chk("dump_timeout", 64'd0, 64'd1);
        chk("beat_count", 64'(nbeats), 64'(v.beats));
        chk("beats_left", 64'(q.size()), 64'd0);
        chk("done_after_last", 64'(done_edge), 64'(last_edge + 1));
        if (v.cycles > 0) chk("start_to_last", 64'(last_edge), 64'(v.cycles));
        ready = 1'b0;
        @(negedge clk);
        chk("busy_after_done", 64'(v_busy), 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk("single_done", 64'(v_done), 64'd0);
            @(negedge clk);
        end
    endtask

    vec_t tbl [6];

    initial begin
        tbl[0] = '{sel:0, stall:0, first:0, beats:32, cycles:64, restart:-1, rnd:1'b0};
        tbl[1] = '{sel:0, stall:3, first:0, beats:32, cycles:-1, restart:-1, rnd:1'b0};
        tbl[2] = '{sel:1, stall:0, first:1, beats:31, cycles:62, restart:-1, rnd:1'b0};
        tbl[3] = '{sel:1, stall:2, first:1, beats:31, cycles:-1, restart:-1, rnd:1'b1};
        tbl[4] = '{sel:0, stall:0, first:0, beats:32, cycles:64, restart:5,  rnd:1'b1};
        tbl[5] = '{sel:0, stall:3, first:0, beats:32, cycles:-1, restart:-1, rnd:1'b1};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0; sel = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(v_busy), 64'd0);

        for (int k = 0; k < 6; k++) begin
            if (tbl[k].rnd) for (int i = 0; i < 32; i++) rf[i] = $urandom;
            run_dump(tbl[k]);
        end

        // Abort while idx 10 waits in SEND without a handshake
        begin
            bit hit = 1'b0;
            sel = 0; start = 1'b1; ready = 1'b1;
            for (int t = 0; t < 200 && !hit; t++) begin
                @(negedge clk);
                start = 1'b0;
                if (v_valid && v_idx == 5'd10) begin
                    ready = 1'b0; abort = 1'b1; hit = 1'b1;
                end
            end
            chk("abort_reached_idx10", 64'(hit), 64'd1);
            @(negedge clk);
            abort = 1'b0;
            chk("abort_valid", 64'(v_valid), 64'd0);
            chk("abort_busy",  64'(v_busy),  64'd0);
            for (int k = 0; k < 3; k++) begin
                chk("abort_no_done", 64'(v_done), 64'd0);
                @(negedge clk);
            end
            run_dump(tbl[0]);
        end

        // Asynchronous reset between clock edges in the middle of a dump
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;
        sel = 0; start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_reset_busy", 64'(v_busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_reset_busy",  64'(v_busy),  64'd0);
            chk("post_reset_valid", 64'(v_valid), 64'd0);
            chk("post_reset_done",  64'(v_done),  64'd0);
        end
        run_dump(tbl[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
